// File: rtl/kbd_pkg.sv
// Shared PS/2 keyboard definitions: LED sequencer state encoding and the
// host/keyboard protocol bytes used by both the sequencer and the scan decoder.
package kbd_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SEND_CMD  = 3'd1,
    S_WAIT_TX1  = 3'd2,
    S_WAIT_ACK1 = 3'd3,
    S_SEND_ARG  = 3'd4,
    S_WAIT_TX2  = 3'd5,
    S_WAIT_ACK2 = 3'd6,
    S_FAIL      = 3'd7
  } kbd_led_state_e;

  localparam logic [7:0] KBD_CMD_SET_LED = 8'hED;
  localparam logic [7:0] KBD_ACK         = 8'hFA;
  localparam logic [7:0] KBD_RESEND      = 8'hFE;

  // States in which the keyboard's reply bytes belong to the LED sequencer.
  function automatic logic kbd_led_owns_rx(kbd_led_state_e s);
    return (s == S_WAIT_TX1) || (s == S_WAIT_ACK1) ||
           (s == S_WAIT_TX2) || (s == S_WAIT_ACK2);
  endfunction

  // States that belong to the argument byte rather than the 0xED command.
  function automatic logic kbd_led_arg_phase(kbd_led_state_e s);
    return (s == S_SEND_ARG) || (s == S_WAIT_TX2) || (s == S_WAIT_ACK2);
  endfunction

endpackage

// File: rtl/kbd_led_seq.sv
// PS/2 keyboard LED update sequencer: sends 0xED + LED argument, waits for
// ACKs, resends on error/timeout, and coalesces requests that arrive while busy.
module kbd_led_seq
  import kbd_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000,
  parameter logic [1:0]  MAX_RETRY   = 2'd3
) (
  input  logic       mclk,
  input  logic       reset_in,
  input  logic       led_req,
  input  logic [2:0] led_val,
  input  logic       scan_dav,
  input  logic [7:0] scan_code,
  output logic       tx_start,
  output logic [7:0] tx_byte,
  input  logic       tx_done,
  input  logic       tx_err,
  output logic       rx_own,
  output logic       busy,
  output logic       err
);

  kbd_led_state_e state_q, state_d;
  logic           pend_q, pend_d;
  logic [2:0]     pend_val_q, pend_val_d;
  logic [2:0]     arg_q, arg_d;
  logic [1:0]     retry_q, retry_d;
  logic [15:0]    to_q, to_d;
  logic           err_q, err_d;
  logic           retry_ev;
  logic           timeout;

  always_ff @(posedge mclk or posedge reset_in) begin
    if (reset_in) begin
      state_q    <= S_IDLE;
      pend_q     <= 1'b0;
      pend_val_q <= 3'd0;
      arg_q      <= 3'd0;
      retry_q    <= 2'd0;
      to_q       <= 16'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      arg_q      <= arg_d;
      retry_q    <= retry_d;
      to_q       <= to_d;
      err_q      <= err_d;
    end
  end

  // >= rather than == so a stray byte landing on the deadline cycle does not
  // push the counter past the compare point and disable the timeout.
  assign timeout = (to_q >= (TIMEOUT_CYC - 16'd1));

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    arg_d      = arg_q;
    retry_d    = retry_q;
    to_d       = 16'd0;
    err_d      = err_q;
    retry_ev   = 1'b0;

    if (led_req) begin
      pend_d     = 1'b1;
      pend_val_d = led_val;
    end

    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          arg_d   = pend_val_q;
          retry_d = 2'd0;
          err_d   = 1'b0;
          state_d = S_SEND_CMD;
          if (!led_req) pend_d = 1'b0;
        end
      end
      S_SEND_CMD: state_d = S_WAIT_TX1;
      S_WAIT_TX1: begin
        if (tx_done)     state_d  = S_WAIT_ACK1;
        else if (tx_err) retry_ev = 1'b1;
      end
      S_WAIT_ACK1: begin
        to_d = to_q + 16'd1;
        if (scan_dav) begin
          if (scan_code == KBD_ACK) begin
            state_d = S_SEND_ARG;
            retry_d = 2'd0;
          end else if (scan_code == KBD_RESEND) begin
            retry_ev = 1'b1;
          end
        end else if (timeout) begin
          retry_ev = 1'b1;
        end
      end
      S_SEND_ARG: state_d = S_WAIT_TX2;
      S_WAIT_TX2: begin
        if (tx_done)     state_d  = S_WAIT_ACK2;
        else if (tx_err) retry_ev = 1'b1;
      end
      S_WAIT_ACK2: begin
        to_d = to_q + 16'd1;
        if (scan_dav) begin
          if (scan_code == KBD_ACK) begin
            state_d = S_IDLE;
            // A pending request for the value just written needs no resend.
            if (pend_d && (pend_val_d == arg_q)) pend_d = 1'b0;
          end else if (scan_code == KBD_RESEND) begin
            retry_ev = 1'b1;
          end
        end else if (timeout) begin
          retry_ev = 1'b1;
        end
      end
      S_FAIL: begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (retry_ev) begin
      if (retry_q < MAX_RETRY) begin
        retry_d = retry_q + 2'd1;
        state_d = kbd_led_arg_phase(state_q) ? S_SEND_ARG : S_SEND_CMD;
      end else begin
        state_d = S_FAIL;
      end
    end
  end

  always_comb begin
    tx_byte = 8'h00;
    case (state_q)
      S_SEND_CMD, S_WAIT_TX1, S_WAIT_ACK1: tx_byte = KBD_CMD_SET_LED;
      S_SEND_ARG, S_WAIT_TX2, S_WAIT_ACK2: tx_byte = {5'b00000, arg_q};
      default:                             tx_byte = 8'h00;
    endcase
  end

  assign tx_start = (state_q == S_SEND_CMD) || (state_q == S_SEND_ARG);
  assign rx_own   = kbd_led_owns_rx(state_q);
  assign busy     = (state_q != S_IDLE);
  assign err      = err_q;

endmodule

// File: doc/kbd_led_seq.md
KBD_LED_SEQ -- requirements
Module: kbd_led_seq

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16'd50000, mclk cycles to wait for a keyboard response byte.
REQ-002 Parameter MAX_RETRY, default 2'd3, number of resends allowed per command byte.
REQ-003 mclk  input  1  system clock; all logic on its rising edge.
REQ-004 reset_in  input  1  asynchronous, active-high reset.
REQ-005 led_req  input  1  one-cycle pulse requesting an LED update.
REQ-006 led_val  input  3  LED state in 0xED argument order: [0] ScrollLock, [1] NumLock, [2] CapsLock (RUS).
REQ-007 scan_dav  input  1  byte-valid strobe from the PS/2 receiver.
REQ-008 scan_code  input  8  received byte.
REQ-009 tx_start  output  1  one-cycle pulse requesting transmission of tx_byte.
REQ-010 tx_byte  output  8  byte to transmit; stable from tx_start until tx_done or tx_err.
REQ-011 tx_done  input  1  one-cycle pulse: transmitter finished, device acknowledged the line.
REQ-012 tx_err  input  1  one-cycle pulse: transmitter aborted.
REQ-013 rx_own  output  1  high while this block consumes received bytes; the scan decoder ignores scan_dav while it is high.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 err  output  1  sticky failure flag; cleared when the next led_req is accepted.

Function
REQ-016 The FSM SHALL have the states IDLE, SEND_CMD, WAIT_TX1, WAIT_ACK1, SEND_ARG, WAIT_TX2, WAIT_ACK2 and FAIL.
REQ-017 In IDLE, a pending request SHALL latch led_val into arg_r and move to SEND_CMD on the next cycle.
REQ-018 SEND_CMD SHALL assert tx_start for exactly one cycle with tx_byte=8'hED, then go to WAIT_TX1. SEND_ARG SHALL do the same with tx_byte={5'b0,arg_r}, then go to WAIT_TX2.
REQ-019 In WAIT_TX1 or WAIT_TX2, tx_done SHALL advance to WAIT_ACK1 or WAIT_ACK2 respectively; tx_err SHALL count as a retry event.
REQ-020 In WAIT_ACKn, the rule on scan_dav SHALL be: scan_code 8'hFA advances (ACK1 to SEND_ARG, ACK2 to IDLE); 8'hFE counts as a retry event; any other byte is discarded and the wait continues.
REQ-021 A 16-bit timeout counter SHALL clear on entry to each WAIT_ACKn state and increment each cycle; reaching TIMEOUT_CYC SHALL count as a retry event.
REQ-022 On a retry event, a retry counter below MAX_RETRY SHALL increment and re-enter the SEND state of the current byte. At MAX_RETRY the FSM SHALL go to FAIL.
REQ-023 The retry counter SHALL clear on entry to SEND_CMD from IDLE and on entry to SEND_ARG from WAIT_ACK1.
REQ-024 FAIL SHALL set err for one state cycle, then return to IDLE. Pending requests are not dropped.
REQ-025 rx_own SHALL be high exactly in WAIT_TX1, WAIT_ACK1, WAIT_TX2 and WAIT_ACK2.
REQ-026 led_req in any state SHALL set a pending flag and overwrite pend_val. Only the latest value is kept (coalescing).
REQ-027 When led_req coincides with the IDLE-to-SEND_CMD transition, it SHALL set pending again, so the newest value is sent afterwards.
REQ-028 On leaving WAIT_ACK2, if pending is set and pend_val equals arg_r, the FSM SHALL clear pending without sending again.
REQ-029 A scan_dav in the same cycle as a timeout SHALL take priority over the timeout.
REQ-030 tx_done or tx_err received outside the WAIT_TXn states SHALL be ignored.

Reset
REQ-031 reset_in high SHALL force the state to IDLE and set tx_start=0, tx_byte=8'h00, rx_own=0, busy=0, err=0, pending=0, arg_r=0, and both counters to 0, including mid-transfer.
REQ-032 After reset, the first led_req SHALL start a full ED/argument sequence.

Structure
REQ-033 The state encoding and the constants 8'hED, 8'hFA and 8'hFE SHALL live in a shared package, kbd_pkg, which the keyboard decoder also uses.
REQ-034 The block SHALL be a single module with no sub-modules. The PS/2 transmitter is external.

Verification
REQ-035 Normal update: led_req with led_val=3'b100; the bench drives tx_done and replies FA twice -> tx_byte sequence ED then 04, busy falls, err=0.
REQ-036 Resend: reply FE after ED -> ED is retransmitted; subsequent FA, FA -> completes with err=0.
REQ-037 Timeout exhaustion: no response after ED -> four ED transmissions, each after TIMEOUT_CYC cycles, then err=1 and return to IDLE.
REQ-038 Coalescing: led_req 3'b001, 3'b010, 3'b100 while busy -> after the first sequence, exactly one further sequence with argument 04.
REQ-039 Reset during WAIT_ACK2 -> all outputs take their reset values within the same cycle; a later led_req starts again with ED.
REQ-040 Stray byte: scan code 1C during WAIT_ACK1, then FA -> 1C is ignored, rx_own stays high, and the sequence continues.
